i2s_tx: RTL and testbench

Audio output serializer clocked by the divided PLL clock (`clkoutd`, ~4.9 MHz) from the Gowin rPLL. It accepts stereo PCM samples over a valid/ready handshake and buffers one sample pair. It generates I2S bit clock, word-select and serial data as a bus master in Philips I2S format, and reports underruns when no sample is ready at a frame boundary.

---
 rtl/i2s_tx.sv | 135 +++++++++++++
 tb/tb_i2s_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S (Philips format) bus-master serializer with a one-pair holding register
// and a valid/ready sample input; zeros are sent and flagged on underrun.
module i2s_tx #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned BCLK_DIV = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                frame_start,
    output logic                underrun,
    output logic [7:0]          underrun_cnt
);

    localparam int unsigned FRAME_W = 2 * SAMPLE_W;
    localparam int unsigned DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned SLOT_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_W - 1);
    localparam logic [SLOT_W-1:0] LR_FIRST  = SLOT_W'(SAMPLE_W - 1);
    localparam logic [SLOT_W-1:0] LR_LAST   = SLOT_W'(FRAME_W - 2);

    logic [DIV_W-1:0]   div_q, div_d;
    logic               bclk_q, bclk_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               lrclk_q, lrclk_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               frame_start_q, frame_start_d;
    logic               underrun_q, underrun_d;
    logic [7:0]         ucnt_q, ucnt_d;

    logic div_tc;
    logic fall_evt;
    logic frame_load;
    logic accept;

    always_comb begin
        div_tc     = (div_q == DIV_LAST);
        fall_evt   = div_tc && bclk_q;
        frame_load = fall_evt && (slot_q == SLOT_LAST);
        accept     = s_valid && !hold_full_q;
    end

    always_comb begin
        div_d         = div_q;
        bclk_d        = bclk_q;
        slot_d        = slot_q;
        lrclk_d       = lrclk_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        ucnt_d        = ucnt_q;

        if (div_tc) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (fall_evt) begin
            slot_d  = frame_load ? '0 : slot_q + 1'b1;
            // Word select flips one slot ahead of each word's MSB.
            lrclk_d = (slot_d >= LR_FIRST) && (slot_d <= LR_LAST);
            if (frame_load) begin
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    shift_d    = '0;
                    underrun_d = 1'b1;
                    if (ucnt_q != 8'hFF) begin
                        ucnt_d = ucnt_q + 8'd1;
                    end
                end
            end else begin
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
        end

        // Accept only while empty, so it never collides with a consuming load;
        // a same-cycle accept on an empty load is kept for the next frame.
        if (accept) begin
            hold_d      = {s_left, s_right};
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            bclk_q        <= 1'b0;
            slot_q        <= SLOT_LAST;
            lrclk_q       <= 1'b0;
            shift_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            ucnt_q        <= 8'd0;
        end else begin
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            slot_q        <= slot_d;
            lrclk_q       <= lrclk_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            ucnt_q        <= ucnt_d;
        end
    end

    assign s_ready      = !hold_full_q;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = shift_q[FRAME_W-1];
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frame-vector table plus reset, late-arrival and
// underrun-saturation sequences, checked against a bit-level frame capture.
module tb_i2s_tx;

    localparam int unsigned W         = 16;
    localparam int unsigned DIV       = 2;
    localparam int unsigned FW        = 2 * W;
    localparam int unsigned FRAME_CYC = FW * 2 * DIV;
    localparam logic [31:0] LR_EXP    = 32'h0001_FFFE;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  s_left;
    logic [W-1:0]  s_right;
    logic          s_valid;
    logic          s_ready;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;
    logic          frame_start;
    logic          underrun;
    logic [7:0]    underrun_cnt;

    i2s_tx #(
        .SAMPLE_W(W),
        .BCLK_DIV(DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_left      (s_left),
        .s_right     (s_right),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] lr;
        logic        ur;
    } frame_t;

    typedef struct {
        logic        valid;
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] exp_word;
        logic        exp_ur;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Receiver model: samples sdata/lrclk on each BCLK rise, one word per frame.
    frame_t      cap_q[$];
    int          fs_cnt;
    int          ur_cnt;
    int          ur_orphan;
    int          bit_idx;
    logic        bclk_prev;
    logic [31:0] cur_word;
    logic [31:0] cur_lr;
    logic        cur_ur;

    initial begin : monitor
        fs_cnt = 0; ur_cnt = 0; ur_orphan = 0; bit_idx = FW; bclk_prev = 1'b0;
        cur_word = '0; cur_lr = '0; cur_ur = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cap_q.delete();
                fs_cnt = 0; ur_cnt = 0; ur_orphan = 0; bit_idx = FW; bclk_prev = 1'b0;
            end else begin
                if (frame_start) begin
                    fs_cnt++;
                    if (underrun) ur_cnt++;
                    cur_ur  = underrun;
                    bit_idx = 0;
                end
                if (underrun && !frame_start) ur_orphan++;
                if (i2s_bclk && !bclk_prev && bit_idx < FW) begin
                    cur_word[FW-1-bit_idx] = i2s_sdata;
                    cur_lr[FW-1-bit_idx]   = i2s_lrclk;
                    bit_idx++;
                    if (bit_idx == FW) cap_q.push_back('{cur_word, cur_lr, cur_ur});
                end
                bclk_prev = i2s_bclk;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"},        i2s_bclk, 0);
        check({tag, "_lrclk"},       i2s_lrclk, 0);
        check({tag, "_sdata"},       i2s_sdata, 0);
        check({tag, "_s_ready"},     s_ready, 1);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_underrun"},    underrun, 0);
        check({tag, "_cnt"},         underrun_cnt, 0);
    endtask

    task automatic wait_fs();
        logic got;
        got = 1'b0;
        for (int i = 0; i < int'(FRAME_CYC) + 8 && !got; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) got = 1'b1;
        end
        check("wait_frame_start", got, 1);
    endtask

    // Called at a negedge; holds s_valid until the handshake edge has passed.
    task automatic send_pair(input logic [15:0] l, input logic [15:0] r,
                             output int waited, output logic rose_with_fs);
        s_left = l; s_right = r; s_valid = 1'b1;
        waited = 0;
        while (s_ready !== 1'b1 && waited < 2 * int'(FRAME_CYC)) begin
            @(negedge clk);
            waited++;
        end
        rose_with_fs = frame_start;
        check("accept_ready", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_left  = 16'($urandom);
        s_right = 16'($urandom);
        check("ready_low_after_accept", s_ready, 0);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[7];
    int   waited;
    logic rose;
    logic pending;
    logic [3:0] exp_bclk;

    initial begin : stim
        tbl[0] = '{1'b1, 16'hA5F0, 16'h0F0F, 32'hA5F0_0F0F, 1'b0};
        tbl[1] = '{1'b1, 16'h1234, 16'hABCD, 32'h1234_ABCD, 1'b0};
        tbl[2] = '{1'b1, 16'hFEDC, 16'h0001, 32'hFEDC_0001, 1'b0};
        tbl[3] = '{1'b0, 16'hDEAD, 16'hBEEF, 32'h0000_0000, 1'b1};
        tbl[4] = '{1'b1, 16'h8000, 16'h7FFF, 32'h8000_7FFF, 1'b0};
        tbl[5] = '{1'b0, 16'hDEAD, 16'hBEEF, 32'h0000_0000, 1'b1};
        tbl[6] = '{1'b1, 16'hFFFF, 16'h0000, 32'hFFFF_0000, 1'b0};

        // Reset with random inputs, then the bring-up timing and pure underruns.
        rst_n = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'($urandom); s_left = 16'($urandom); s_right = 16'($urandom);
            #1 check_reset_outputs("in_reset");
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        exp_bclk = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("bclk_after_edge%0d", k + 1), i2s_bclk, exp_bclk[k]);
            check($sformatf("fs_after_edge%0d", k + 1), frame_start, (k == 3) ? 1 : 0);
        end
        check("first_load_underrun", underrun, 1);
        check("first_load_sdata", i2s_sdata, 0);
        wait_fs();
        wait_fs();
        check("underrun_on_third", underrun, 1);
        check("cnt_after_three", underrun_cnt, 3);
        #2;
        check("mon_underruns", ur_cnt, 3);
        check("mon_orphan_underrun", ur_orphan, 0);
        wait_fs();
        #2;
        check("cap_size_underrun", cap_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ur_frame%0d_word", i), cap_q[i].word, 0);
            check($sformatf("ur_frame%0d_lr", i), cap_q[i].lr, LR_EXP);
        end

        // Late arrival: valid presented for the load edge itself with hold empty.
        repeat (FRAME_CYC - 1) @(negedge clk);
        s_left = 16'h5A5A; s_right = 16'hC3C3; s_valid = 1'b1;
        @(negedge clk);
        check("late_fs", frame_start, 1);
        check("late_underrun", underrun, 1);
        check("late_ready_low", s_ready, 0);
        s_valid = 1'b0; s_left = 16'($urandom); s_right = 16'($urandom);
        check("late_cnt", underrun_cnt, 5);
        wait_fs();
        check("late_next_no_underrun", underrun, 0);
        wait_fs();
        #2;
        check("cap_size_late", cap_q.size(), 6);
        check("late_frame_zero", cap_q[4].word, 0);
        check("late_frame_ur", cap_q[4].ur, 1);
        check("late_pair_word", cap_q[5].word, 32'h5A5A_C3C3);
        check("late_pair_ur", cap_q[5].ur, 0);

        // Mid-frame asynchronous reset while the holding register is full.
        @(negedge clk);
        send_pair(16'h1111, 16'h2222, waited, rose);
        repeat (21) @(negedge clk);
        check("hold_full_before_reset", s_ready, 0);
        check("cnt_before_reset", underrun_cnt, 6);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);

        // Vector table: back-to-back pairs with gaps, released straight out of reset.
        rst_n   = 1'b1;
        pending = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].valid) begin
                send_pair(tbl[i].l, tbl[i].r, waited, rose);
                if (i == 0) check("first_accept_cycle0", waited, 0);
                else if (pending) check($sformatf("vec%0d_ready_with_load", i), rose, 1);
                pending = 1'b1;
            end else begin
                if (pending) wait_fs();
                wait_fs();
                pending = 1'b0;
            end
        end
        if (pending) wait_fs();
        check("vec_cnt", underrun_cnt, 2);
        check("vec_last_no_underrun", underrun, 0);
        wait_fs();
        #2;
        check("cap_size_vec", cap_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("vec%0d_word", i), cap_q[i].word, tbl[i].exp_word);
            check($sformatf("vec%0d_lr", i), cap_q[i].lr, LR_EXP);
            check($sformatf("vec%0d_ur", i), cap_q[i].ur, tbl[i].exp_ur);
        end

        // Saturation of the underrun counter.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 260; f++) begin
            wait_fs();
            if (f == 253) check("cnt_254", underrun_cnt, 254);
            if (f == 254) check("cnt_255", underrun_cnt, 255);
            if (f == 255) check("cnt_hold_255", underrun_cnt, 255);
        end
        check("cnt_final", underrun_cnt, 255);
        check("underrun_still_pulses", underrun, 1);
        #2;
        check("mon_sat_underruns", ur_cnt, 260);
        check("mon_sat_orphan", ur_orphan, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
